// File: rtl/ttc_clk_prescale_lite2_pkg.sv
// ---------------------------------------------------------------------------
// ttc_pkg2 - shared definitions for the TTC clock prescaler slice.
//   * Bit positions inside the 7-bit clock control register.
//   * ttc_clk_ctrl_t : the control register type.
//   * ratio_exp()    : log2 of the requested divide ratio (before saturation).
// ---------------------------------------------------------------------------
package ttc_pkg2;

  localparam int CC_PS_EN    = 0;
  localparam int CC_PS_LO    = 1;
  localparam int CC_PS_HI    = 4;
  localparam int CC_EXT_SEL  = 5;
  localparam int CC_EXT_EDGE = 6;

  typedef logic [6:0] ttc_clk_ctrl_t;

  // Returns N+1 when the prescaler is enabled, 0 (ratio 1) otherwise.
  // The caller saturates against its own counter width.
  function automatic logic [4:0] ratio_exp(input ttc_clk_ctrl_t c);
    if (c[CC_PS_EN]) begin
      return {1'b0, c[CC_PS_HI:CC_PS_LO]} + 5'd1;
    end
    return 5'd0;
  endfunction

endpackage

// File: rtl/ttc_clk_prescale_lite2_if.sv
// ---------------------------------------------------------------------------
// ttc_clk_prescale_lite2_if - signal bundle between the TTC reset block /
// external clock pin and the prescaler, plus the tick/status back out.
//   clk_ctrl_reg2 : clock control register (ttc_clk_ctrl_t)
//   count_en2     : counter enable; low clears the prescaler
//   ext_clk2      : asynchronous external timer clock
//   count_tick2   : registered one-cycle count pulse
//   ps_count2     : current prescale count
// There is no valid/ready handshake here: every input is level-sampled on
// each rising pclk2 edge, and count_tick2 is a single-cycle strobe that the
// consumer must accept in the cycle it is high (no back-pressure).
// Modports: master drives control/external clock, slave is the prescaler.
// ---------------------------------------------------------------------------
interface ttc_clk_prescale_lite2_if #(
  parameter int PS_WIDTH = 16
);
  import ttc_pkg2::*;

  ttc_clk_ctrl_t         clk_ctrl_reg2;
  logic                  count_en2;
  logic                  ext_clk2;
  logic                  count_tick2;
  logic [PS_WIDTH-1:0]   ps_count2;

  modport master (
    output clk_ctrl_reg2,
    output count_en2,
    output ext_clk2,
    input  count_tick2,
    input  ps_count2
  );

  modport slave (
    input  clk_ctrl_reg2,
    input  count_en2,
    input  ext_clk2,
    output count_tick2,
    output ps_count2
  );

endinterface

// File: rtl/ttc_ext_sync_lite2.sv
// ---------------------------------------------------------------------------
// ttc_ext_sync_lite2 - synchroniser and edge detector for the external clock.
//   clk_i     : pclk2
//   rst_i     : synchronous active-high reset
//   ext_clk_i : asynchronous external clock
//   rise_o    : one-cycle pulse after a synchronised rising edge
//   fall_o    : one-cycle pulse after a synchronised falling edge
// The flops run every cycle so the history is always current when the
// external source is selected later.  SYNC_STAGES legal range is 2..4.
// ---------------------------------------------------------------------------
module ttc_ext_sync_lite2 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ext_clk_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   s_last;

  assign s_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_clk_i};
      hist_q <= s_last;
    end
  end

  assign rise_o = s_last & ~hist_q;
  assign fall_o = ~s_last & hist_q;

endmodule

// File: rtl/ttc_clk_prescale_lite2.sv
// ---------------------------------------------------------------------------
// ttc_clk_prescale_lite2 - timer clock-enable generator for the TTC counter.
//   pclk2    : system clock, all logic on the rising edge
//   p_reset2 : synchronous, active-high reset
//   bus      : slave side of ttc_clk_prescale_lite2_if
//              (clk_ctrl_reg2, count_en2, ext_clk2 in; count_tick2, ps_count2 out)
// Source events come from pclk2 (every cycle) or a synchronised edge of
// ext_clk2; every R-th event produces a registered one-cycle count_tick2.
// R = 1, or 2^(N+1) saturated to 2^PS_WIDTH.
// Any change of the control register restarts the prescaler from 0.
// ---------------------------------------------------------------------------
module ttc_clk_prescale_lite2 #(
  parameter int PS_WIDTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          pclk2,
  input  logic                          p_reset2,
  ttc_clk_prescale_lite2_if.slave       bus
);
  import ttc_pkg2::*;

  ttc_clk_ctrl_t        ctrl;
  ttc_clk_ctrl_t        shadow_q, shadow_d;
  logic [PS_WIDTH-1:0]  cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic [PS_WIDTH-1:0]  term;
  logic [4:0]           rexp;
  logic                 ext_rise, ext_fall;
  logic                 src_evt;

  assign ctrl = bus.clk_ctrl_reg2;

  ttc_ext_sync_lite2 #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .clk_i     (pclk2),
    .rst_i     (p_reset2),
    .ext_clk_i (bus.ext_clk2),
    .rise_o    (ext_rise),
    .fall_o    (ext_fall)
  );

  assign src_evt = ctrl[CC_EXT_SEL] ? (ctrl[CC_EXT_EDGE] ? ext_fall : ext_rise)
                                    : 1'b1;

  // Terminal count R-1; exponents at or beyond the counter width saturate
  // to all ones, i.e. R = 2^PS_WIDTH.
  assign rexp = ratio_exp(ctrl);

  always_comb begin
    term = '0;
    if (32'(rexp) >= PS_WIDTH) begin
      term = '1;
    end else begin
      term = (PS_WIDTH'(1) << rexp) - PS_WIDTH'(1);
    end
  end

  // Prescaler next state, highest priority first.  With the prescaler
  // disabled the shadow is not refreshed, so a control change made while
  // disabled still forces one restart cycle once count_en2 returns.
  always_comb begin
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    shadow_d = shadow_q;
    if (!bus.count_en2) begin
      cnt_d = '0;
    end else if (ctrl != shadow_q) begin
      cnt_d    = '0;
      shadow_d = ctrl;
    end else if (src_evt) begin
      if (cnt_q >= term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge pclk2) begin
    if (p_reset2) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.count_tick2 = tick_q;
  assign bus.ps_count2   = cnt_q;

endmodule

// File: tb/tb_ttc_clk_prescale_lite2.sv
// ---------------------------------------------------------------------------
// tb_ttc_clk_prescale_lite2 - directed bench for ttc_clk_prescale_lite2.
// Each step() drives one cycle of inputs, advances a cycle-level reference
// model, pushes its expected {tick,count} to exp_q, clocks the DUT and pops
// and compares one entry.  Directed checks on top cover the named scenarios.
// ---------------------------------------------------------------------------
module tb_ttc_clk_prescale_lite2;

  localparam int PS_WIDTH = 16;
  localparam int SYNC     = 2;
  localparam int W        = PS_WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic pclk2 = 1'b0;
  logic p_reset2 = 1'b1;
  always #5 pclk2 = ~pclk2;

  ttc_clk_prescale_lite2_if #(.PS_WIDTH(PS_WIDTH)) bus_if ();

  ttc_clk_prescale_lite2 #(
    .PS_WIDTH    (PS_WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .pclk2    (pclk2),
    .p_reset2 (p_reset2),
    .bus      (bus_if)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  longint m_cnt    = 0;
  logic   m_tick   = 1'b0;
  logic [6:0] m_shadow = 7'h00;
  logic   m_hist [0:SYNC];

  logic obs_tick;
  logic [PS_WIDTH-1:0] obs_cnt;

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input logic [6:0] ctrl, input logic en,
                            input logic ext, input logic rst);
    logic   evt;
    logic   s_last, h;
    longint r;
    int     nplus;
    if (rst) begin
      m_cnt    = 0;
      m_tick   = 1'b0;
      m_shadow = 7'h00;
      for (int i = 0; i <= SYNC; i++) m_hist[i] = 1'b0;
    end else begin
      s_last = m_hist[SYNC-1];
      h      = m_hist[SYNC];
      if (!ctrl[5])     evt = 1'b1;
      else if (ctrl[6]) evt = !s_last && h;
      else              evt = s_last && !h;
      nplus = int'(ctrl[4:1]) + 1;
      if (!ctrl[0])                r = 1;
      else if (nplus >= PS_WIDTH)  r = longint'(1) << PS_WIDTH;
      else                         r = longint'(1) << nplus;
      m_tick = 1'b0;
      if (!en) begin
        m_cnt = 0;
      end else if (ctrl != m_shadow) begin
        m_cnt    = 0;
        m_shadow = ctrl;
      end else if (evt) begin
        if (m_cnt == r - 1) begin
          m_cnt  = 0;
          m_tick = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ext;
    end
    exp_q.push_back({m_tick, m_cnt[PS_WIDTH-1:0]});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [6:0] ctrl, input logic en,
                      input logic ext, input logic rst);
    logic [W-1:0] e;
    bus_if.clk_ctrl_reg2 = ctrl;
    bus_if.count_en2     = en;
    bus_if.ext_clk2      = ext;
    p_reset2             = rst;
    model_step(ctrl, en, ext, rst);
    @(posedge pclk2);
    #1;
    cyc++;
    obs_tick = bus_if.count_tick2;
    obs_cnt  = bus_if.ps_count2;
    e = exp_q.pop_front();
    checks++;
    assert ({obs_tick, obs_cnt} === e) else begin
      errors++;
      $error("FAIL scoreboard cyc=%0d obs=%h exp=%h", cyc, {obs_tick, obs_cnt}, e);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ticks;
    int last_edge;
    int first_tick;
    int seq [8];
    seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    bus_if.clk_ctrl_reg2 = 7'h00;
    bus_if.count_en2     = 1'b0;
    bus_if.ext_clk2      = 1'b0;
    for (int i = 0; i <= SYNC; i++) m_hist[i] = 1'b0;

    // reset
    for (int i = 0; i < 3; i++) step(7'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_tick", obs_tick, 0);
    chk("rst_cnt", obs_cnt, 0);

    // T1: internal source, R=1 -> tick every cycle from the first enabled edge
    for (int i = 0; i < 8; i++) begin
      step(7'h00, 1'b1, 1'b0, 1'b0);
      chk("t1_tick", obs_tick, 1);
      chk("t1_cnt", obs_cnt, 0);
    end

    // T2: R=4
    step(7'h03, 1'b1, 1'b0, 1'b0);
    chk("t2_chg_cnt", obs_cnt, 0);
    chk("t2_chg_tick", obs_tick, 0);
    for (int i = 0; i < 8; i++) begin
      step(7'h03, 1'b1, 1'b0, 1'b0);
      chk("t2_cnt", obs_cnt, seq[i]);
      chk("t2_tick", obs_tick, (seq[i] == 0) ? 1 : 0);
    end

    // T3: external rising, R=2, 10 periods of 6 cycles
    step(7'h21, 1'b1, 1'b0, 1'b0);
    chk("t3_chg_cnt", obs_cnt, 0);
    ticks = 0;
    last_edge = -100;
    for (int p = 0; p < 10; p++) begin
      for (int ph = 0; ph < 6; ph++) begin
        step(7'h21, 1'b1, (ph < 3), 1'b0);
        if (ph == 0) last_edge = cyc;
        if (obs_tick) begin
          ticks++;
          chk("t3_latency", cyc - last_edge, SYNC);
        end
      end
    end
    for (int i = 0; i < SYNC + 2; i++) begin
      step(7'h21, 1'b1, 1'b0, 1'b0);
      if (obs_tick) ticks++;
    end
    chk("t3_ticks", ticks, 5);

    // external source, ext_clk2 static high after one rise: counter holds at 1
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(7'h21, 1'b1, 1'b1, 1'b0);
      if (obs_tick) ticks++;
    end
    chk("static_cnt", obs_cnt, 1);
    chk("static_ticks", ticks, 0);
    for (int i = 0; i < 4; i++) step(7'h21, 1'b1, 1'b0, 1'b0);
    chk("static_fall_cnt", obs_cnt, 1);

    // T4: external falling, R=2
    step(7'h61, 1'b1, 1'b0, 1'b0);
    chk("t4_chg_cnt", obs_cnt, 0);
    ticks = 0;
    last_edge = -100;
    for (int p = 0; p < 10; p++) begin
      for (int ph = 0; ph < 6; ph++) begin
        step(7'h61, 1'b1, (ph < 3), 1'b0);
        if (ph == 3) last_edge = cyc;
        if (obs_tick) begin
          ticks++;
          chk("t4_latency", cyc - last_edge, SYNC);
        end
      end
    end
    for (int i = 0; i < SYNC + 2; i++) begin
      step(7'h61, 1'b1, 1'b0, 1'b0);
      if (obs_tick) ticks++;
    end
    chk("t4_ticks", ticks, 5);

    // T5: R=16, restart via count_en2 at count 9
    step(7'h07, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(7'h07, 1'b1, 1'b0, 1'b0);
    chk("t5_cnt9", obs_cnt, 9);
    step(7'h07, 1'b0, 1'b0, 1'b0);
    chk("t5_off_cnt", obs_cnt, 0);
    chk("t5_off_tick", obs_tick, 0);
    first_tick = -1;
    for (int i = 1; i <= 20; i++) begin
      step(7'h07, 1'b1, 1'b0, 1'b0);
      if (obs_tick && first_tick < 0) first_tick = i;
    end
    chk("t5_first_tick", first_tick, 16);

    // T6: ctrl rewrite 03 -> 05 at count 2 with src_evt active
    step(7'h03, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(7'h03, 1'b1, 1'b0, 1'b0);
    chk("t6_cnt2", obs_cnt, 2);
    step(7'h05, 1'b1, 1'b0, 1'b0);
    chk("t6_chg_cnt", obs_cnt, 0);
    chk("t6_chg_tick", obs_tick, 0);
    first_tick = -1;
    for (int i = 1; i <= 11; i++) begin
      step(7'h05, 1'b1, 1'b0, 1'b0);
      if (obs_tick && first_tick < 0) first_tick = i;
    end
    chk("t6_first_tick", first_tick, 8);
    chk("t6_cnt3", obs_cnt, 3);
    step(7'h05, 1'b1, 1'b0, 1'b1);
    chk("t6_rst_cnt", obs_cnt, 0);
    chk("t6_rst_tick", obs_tick, 0);
    step(7'h05, 1'b1, 1'b0, 1'b0);
    chk("t6_post_rst_cnt", obs_cnt, 0);

    // saturated ratio (N=15 -> 2^16): counts up without wrapping
    step(7'h1F, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(7'h1F, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", obs_cnt, 5);
    chk("sat_tick", obs_tick, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
